// File: rtl/wb_buf_arbiter_pkg.sv
// Shared constants, state encoding and sizing helper for the buffer-manager Wishbone arbiter.
package wb_buf_arbiter_pkg;

  localparam logic [31:0] BUF_MANAGER_BASE_ADDR = 32'h0000_1000;
  localparam int          WB_ARB_STATE_W        = 2;
  localparam int          WB_ARB_TIMEOUT        = 1024;

  typedef enum logic [WB_ARB_STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } arb_state_t;

  // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_buf_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above rr_ptr, wrapping modulo NUM_MASTERS.
module wb_buf_arbiter_rr_pick
  import wb_buf_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int IDX_W       = clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [NUM_MASTERS-1:0] grant_oh,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_oh = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_MASTERS);
      if (!valid && req[cand]) begin
        valid          = 1'b1;
        idx            = cand;
        grant_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_buf_arbiter.sv
// Round-robin Wishbone arbiter sharing the buffer-manager slave; owners hold the bus for a whole
// cycle and a watchdog converts a missing ack into a one-cycle error pulse.
module wb_buf_arbiter
  import wb_buf_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = WB_ARB_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_writedata,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_readdata,
  input  logic [NUM_MASTERS-1:0]            m_strobe,
  input  logic [NUM_MASTERS-1:0]            m_cycle,
  input  logic [NUM_MASTERS-1:0]            m_write,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [ADDR_WIDTH-1:0]             s_address,
  output logic [DATA_WIDTH-1:0]             s_writedata,
  input  logic [DATA_WIDTH-1:0]             s_readdata,
  output logic                              s_strobe,
  output logic                              s_cycle,
  output logic                              s_write,
  input  logic                              s_ack,
  output logic [NUM_MASTERS-1:0]            grant
);

  localparam int               IDX_W    = clog2(NUM_MASTERS);
  localparam int               WD_W     = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);

  arb_state_t               state;
  arb_state_t               state_next;
  logic [IDX_W-1:0]         owner;
  logic [NUM_MASTERS-1:0]   owner_oh;
  logic [IDX_W-1:0]         rr_ptr;
  logic [WD_W-1:0]          watchdog;
  logic                     err_first;
  logic [NUM_MASTERS-1:0]   pick_oh;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_valid;
  logic                     owner_cycle;
  logic                     owner_strobe;
  logic                     wd_hit;

  wb_buf_arbiter_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr_pick (
    .req      (m_cycle),
    .rr_ptr   (rr_ptr),
    .grant_oh (pick_oh),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

  assign owner_cycle  = m_cycle[owner];
  assign owner_strobe = m_strobe[owner];
  assign m_readdata   = {NUM_MASTERS{s_readdata}};

  // The limit fires on the stalled cycle that would bring the count to TIMEOUT, so an ack on that cycle still wins.
  assign wd_hit = (TIMEOUT != 0) && (state == ST_BUSY) && owner_strobe && !s_ack
                  && (watchdog == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (pick_valid) state_next = ST_BUSY;
      ST_BUSY: begin
        if (!owner_cycle) state_next = ST_IDLE;
        else if (wd_hit)  state_next = ST_ERR;
      end
      ST_ERR:  if (!owner_cycle) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= '0;
      owner_oh  <= '0;
      rr_ptr    <= '0;
      watchdog  <= '0;
      err_first <= 1'b0;
    end else begin
      err_first <= (state == ST_BUSY) && (state_next == ST_ERR);
      if ((state == ST_IDLE) && pick_valid) begin
        owner    <= pick_idx;
        owner_oh <= pick_oh;
      end
      if ((state != ST_IDLE) && !owner_cycle)
        rr_ptr <= (owner == IDX_LAST) ? '0 : owner + IDX_W'(1);
      if ((TIMEOUT != 0) && (state == ST_BUSY) && owner_strobe && !s_ack)
        watchdog <= watchdog + WD_W'(1);
      else
        watchdog <= '0;
    end
  end

  always_comb begin
    s_cycle     = 1'b0;
    s_strobe    = 1'b0;
    s_write     = 1'b0;
    s_address   = '0;
    s_writedata = '0;
    m_ack       = '0;
    m_err       = '0;
    grant       = '0;
    case (state)
      ST_BUSY: begin
        grant       = owner_oh;
        s_cycle     = owner_cycle;
        s_strobe    = owner_strobe;
        s_write     = m_write[owner];
        s_address   = m_address[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
        s_writedata = m_writedata[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
        if (s_ack) m_ack = owner_oh;
      end
      ST_ERR: begin
        grant = owner_oh;
        if (err_first) m_err = owner_oh;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/wb_buf_arbiter.md
Name: wb_buf_arbiter

Overview:
Round-robin Wishbone arbiter that shares the single buffer-manager slave at BUF_MANAGER_BASE_ADDR among NUM_MASTERS requesters: control logic, image updater and LED sender. Each master keeps its bus for the whole of its cycle, so an alloc/release transaction is never interleaved. A watchdog aborts transactions that receive no ack and returns a one-cycle error to the owning master.

Parameters:
NUM_MASTERS, 3, number of requesting Wishbone masters (2..8)
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 32, Wishbone data width
TIMEOUT, 1024, cycles with strobe high and no ack before abort; 0 disables the watchdog

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m_address  in  NUM_MASTERS*ADDR_WIDTH  master addresses, master i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
m_writedata  in  NUM_MASTERS*DATA_WIDTH  master write data, same slicing
m_readdata  out  NUM_MASTERS*DATA_WIDTH  read data; every slice carries s_readdata
m_strobe  in  NUM_MASTERS  per-master strobe
m_cycle  in  NUM_MASTERS  per-master cycle (bus request)
m_write  in  NUM_MASTERS  per-master write enable
m_ack  out  NUM_MASTERS  ack, routed to the granted master only
m_err  out  NUM_MASTERS  one-cycle timeout error pulse to the granted master
s_address  out  ADDR_WIDTH  slave address
s_writedata  out  DATA_WIDTH  slave write data
s_readdata  in  DATA_WIDTH  slave read data
s_strobe  out  1  slave strobe
s_cycle  out  1  slave cycle
s_write  out  1  slave write enable
s_ack  in  1  slave ack
grant  out  NUM_MASTERS  one-hot current owner, all zero when idle (debug and status)

Behaviour:
- Reset: state=ST_IDLE; grant=0; rr_ptr=0; watchdog=0. All s_* outputs 0. m_ack=0 and m_err=0.
- States: ST_IDLE, ST_BUSY, ST_ERR.
- ST_IDLE: if any m_cycle bit is high, select the first requester found searching upward from rr_ptr, wrapping modulo NUM_MASTERS. Register its index as owner and go to ST_BUSY. Grant latency is one clock from m_cycle to s_cycle.
- ST_BUSY: s_cycle, s_strobe, s_write, s_address and s_writedata are combinationally muxed from the owner. m_ack[owner]=s_ack; all other m_ack bits are 0.
- ST_BUSY exit: when m_cycle[owner] falls, go to ST_IDLE and set rr_ptr=(owner+1) mod NUM_MASTERS. There is one idle cycle between owners.
- Multiple strobes inside one held cycle are passed through; ownership does not change while m_cycle[owner] stays high.
- Watchdog: counts while in ST_BUSY with s_strobe=1 and s_ack=0. It clears on s_ack or when s_strobe=0. When TIMEOUT!=0 and the count reaches TIMEOUT, go to ST_ERR.
- ST_ERR: s_cycle and s_strobe are forced to 0. m_err[owner]=1 for the first ST_ERR cycle only. Stay in ST_ERR until m_cycle[owner]=0, then go to ST_IDLE and advance rr_ptr as in a normal exit.
- Requests from non-owners are held off; they receive neither ack nor err.
- s_ack arriving in ST_IDLE or ST_ERR is ignored.
- Simultaneous s_ack and watchdog limit: the ack wins and the counter clears.
- Owner drops m_cycle on the same cycle its ack arrives: the ack is delivered, then ST_IDLE.
- Reset mid-transaction: everything returns to reset values immediately; the slave sees s_cycle fall asynchronously.
- The index width is clog2(NUM_MASTERS), implemented as a local constant function. The watchdog width is clog2(TIMEOUT+1).

Decomposition:
- globals.vh: add arbiter constants WB_ARB_STATE_W and the default timeout WB_ARB_TIMEOUT. BUF_MANAGER_BASE_ADDR stays in globals.vh.
- One natural sub-module: rr_pick. It is combinational and takes request vector and rr_ptr, and returns a one-hot grant, the owner index and a valid flag. It is unit-testable on its own.

Test Plan:
- Master 1 alone raises cycle/strobe (read), slave acks after 3 cycles with readdata=0x5 -> grant=3'b010 one clock after request; m_ack=3'b010 for one cycle; m_readdata slice 1=0x5; grant returns to 0 after cycle falls.
- All three masters request at once and each drops cycle after its ack -> service order 0,1,2 with rr_ptr=0 after reset. Then only master 0 re-requests -> served next.
- Master 2 holds cycle across two strobes (alloc read, then release write with writedata=0x7) while master 0 requests -> master 0 is not granted until master 2 drops cycle; s_write=1 only on the second access.
- Slave never acks with TIMEOUT=16 -> 16 strobe cycles, then s_cycle=0, m_err[owner] pulses exactly once, and the arbiter stays in ST_ERR until the owner drops cycle.
- s_ack coincident with watchdog count=TIMEOUT -> m_ack delivered, no m_err.
- Reset asserted mid-transaction with master 1 owning the bus -> s_cycle=0 and grant=0 immediately. After release, with masters 1 and 2 requesting, master 1 is granted first, because rr_ptr has returned to 0.
